// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM bank arbiter.
// Owner encoding and burst counter sizing.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_e;

  localparam int DEFAULT_MAX_BURST = 16;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_bank_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// On contention the side not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Prefer the requester that was not served last
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_bank_arbiter.sv
// Shares one RAM port between two requesters.
// Round-robin with bounded burst lock.
module ram_bank_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  we0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam int CW = burst_cnt_w(MAX_BURST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    pick;
  logic [1:0]    gnt;
  logic          hold0, hold1;
  logic          at_limit;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (last_q),
    .gnt  (pick)
  );

  assign hold0    = (owner_q == OWN_R0) && req0;
  assign hold1    = (owner_q == OWN_R1) && req1;
  assign at_limit = (cnt_q == MAX_CNT);
  assign cnt_inc  = at_limit ? cnt_q : cnt_q + CW'(1);

  // Grant: locked owner keeps the port until its burst budget runs out
  always_comb begin
    gnt = 2'b00;
    if (!rstn) begin
      gnt = 2'b00;
    end else if (hold0) begin
      gnt = (at_limit && req1) ? 2'b10 : 2'b01;
    end else if (hold1) begin
      gnt = (at_limit && req0) ? 2'b01 : 2'b10;
    end else begin
      gnt = pick;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Beat mux toward the RAM port; idle port drives zeros
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        ram_we    = we0;
        ram_addr  = addr0;
        ram_wdata = wdata0;
      end
      gnt[1]: begin
        ram_we    = we1;
        ram_addr  = addr1;
        ram_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // Ownership, burst count and rr pointer for the next cycle
  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt[0]) begin
      last_d = 1'b0;
      if (lock0) begin
        owner_d = OWN_R0;
        cnt_d   = (owner_q == OWN_R0) ? cnt_inc : CW'(1);
      end
    end else if (gnt[1]) begin
      last_d = 1'b1;
      if (lock1) begin
        owner_d = OWN_R1;
        cnt_d   = (owner_q == OWN_R1) ? cnt_inc : CW'(1);
      end
    end
  end

  // State registers; last=1 makes requester 0 preferred after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Read-valid pipeline matching the 1-cycle RAM latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt[0] & ~we0;
      rvalid1 <= gnt[1] & ~we1;
    end
  end

  assign rdata0 = ram_rdata;
  assign rdata1 = ram_rdata;
  assign busy   = (|gnt) | (owner_q != OWN_NONE);

endmodule
